// File: rtl/alu_dmem_unit.sv
// alu_dmem_unit: execute + memory slice of the 5-stage core.
// Combinational ALU-control decode and 32-bit ALU feeding EX/MEM, plus a
// little-endian byte-addressable data memory read by the MEM stage.
// Optional feature macro: ALU_OVERFLOW_EN (signed add/sub overflow flag).
module alu_dmem_unit #(
    parameter int DMEM_WORDS = 256,
    parameter int DMEM_AW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] alu_result,
    output logic        zero_flag,
    output logic [3:0]  alu_ctrl,
    output logic        ovf,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_wr_rd,
    input  logic        word_byte,
    output logic [31:0] mem_rdata
);

    localparam logic [3:0] CTRL_AND  = 4'd0;
    localparam logic [3:0] CTRL_OR   = 4'd1;
    localparam logic [3:0] CTRL_ADD  = 4'd2;
    localparam logic [3:0] CTRL_XOR  = 4'd3;
    localparam logic [3:0] CTRL_SLL  = 4'd4;
    localparam logic [3:0] CTRL_SRL  = 4'd5;
    localparam logic [3:0] CTRL_SUB  = 4'd6;
    localparam logic [3:0] CTRL_SLT  = 4'd7;
    localparam logic [3:0] CTRL_SRA  = 4'd8;
    localparam logic [3:0] CTRL_SLTU = 4'd9;
    localparam logic [3:0] CTRL_NOR  = 4'd12;
    localparam logic [3:0] CTRL_BAD  = 4'd15;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    logic [3:0]         alu_ctrl_s;
    logic [31:0]        alu_result_s;
    logic               ovf_s;
    logic [31:0]        mem_r [DMEM_WORDS];
    logic [DMEM_AW-1:0] word_idx_s;
    logic [4:0]         lane_shift_s;
    logic [31:0]        word_rd_s;
    logic [7:0]         byte_rd_s;
    logic [31:0]        mem_rdata_s;
    logic               addr_unused_s;

    // Sign-extend a loaded byte to a full word.
    function automatic logic [31:0] sext8(input logic [7:0] b);
        sext8 = {{24{b[7]}}, b};
    endfunction

    // Decode the control-unit operation class (and funct for R-type) into an ALU code.
    always_comb begin
        alu_ctrl_s = CTRL_BAD;
        case (alu_op)
            3'b000:  alu_ctrl_s = CTRL_ADD;
            3'b001:  alu_ctrl_s = CTRL_SUB;
            3'b011:  alu_ctrl_s = CTRL_AND;
            3'b100:  alu_ctrl_s = CTRL_OR;
            3'b101:  alu_ctrl_s = CTRL_SLT;
            3'b110:  alu_ctrl_s = CTRL_XOR;
            3'b111:  alu_ctrl_s = CTRL_ADD;
            3'b010: begin
                case (funct)
                    6'h20, 6'h21: alu_ctrl_s = CTRL_ADD;
                    6'h22, 6'h23: alu_ctrl_s = CTRL_SUB;
                    6'h24:        alu_ctrl_s = CTRL_AND;
                    6'h25:        alu_ctrl_s = CTRL_OR;
                    6'h26:        alu_ctrl_s = CTRL_XOR;
                    6'h27:        alu_ctrl_s = CTRL_NOR;
                    6'h2A:        alu_ctrl_s = CTRL_SLT;
                    6'h2B:        alu_ctrl_s = CTRL_SLTU;
                    6'h00:        alu_ctrl_s = CTRL_SLL;
                    6'h02:        alu_ctrl_s = CTRL_SRL;
                    6'h03:        alu_ctrl_s = CTRL_SRA;
                    6'h08:        alu_ctrl_s = CTRL_ADD; // jr: address passes through the adder
                    default:      alu_ctrl_s = CTRL_BAD;
                endcase
            end
            default: alu_ctrl_s = CTRL_BAD;
        endcase
    end

    // Stateless 32-bit ALU; shifts operate on op2 and ignore op1.
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_ctrl_s)
            CTRL_AND:  alu_result_s = op1 & op2;
            CTRL_OR:   alu_result_s = op1 | op2;
            CTRL_ADD:  alu_result_s = op1 + op2;
            CTRL_XOR:  alu_result_s = op1 ^ op2;
            CTRL_SLL:  alu_result_s = op2 << shamt;
            CTRL_SRL:  alu_result_s = op2 >> shamt;
            CTRL_SUB:  alu_result_s = op1 - op2;
            CTRL_SLT:  alu_result_s = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
            CTRL_SRA:  alu_result_s = $unsigned($signed(op2) >>> shamt);
            CTRL_SLTU: alu_result_s = (op1 < op2) ? 32'd1 : 32'd0;
            CTRL_NOR:  alu_result_s = ~(op1 | op2);
            default:   alu_result_s = 32'd0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow: result sign disagrees with what the operand signs imply.
    always_comb begin
        ovf_s = 1'b0;
        if (alu_ctrl_s == CTRL_ADD) begin
            ovf_s = (op1[31] == op2[31]) && (alu_result_s[31] != op1[31]);
        end else if (alu_ctrl_s == CTRL_SUB) begin
            ovf_s = (op1[31] != op2[31]) && (alu_result_s[31] != op1[31]);
        end else begin
            ovf_s = 1'b0;
        end
    end
`else
    assign ovf_s = 1'b0;
`endif

    assign alu_ctrl   = alu_ctrl_s;
    assign alu_result = alu_result_s;
    assign zero_flag  = (alu_result_s == 32'd0);
    assign ovf        = ovf_s;

    // Upper address bits are deliberately ignored so addresses alias.
    assign addr_unused_s = ^{mem_addr[31:DMEM_AW+2]};
    assign word_idx_s    = mem_addr[DMEM_AW+1:2];
    assign lane_shift_s  = {mem_addr[1:0], 3'b000};

    // Memory array: reset clears every word and overrides any write in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (mem_wr_rd == MEM_WRITE) begin
            if (word_byte) begin
                mem_r[word_idx_s][lane_shift_s +: 8] <= mem_wdata[7:0];
            end else begin
                mem_r[word_idx_s] <= mem_wdata;
            end
        end else begin
            mem_r[word_idx_s] <= mem_r[word_idx_s];
        end
    end

    assign word_rd_s = mem_r[word_idx_s];
    assign byte_rd_s = 8'(word_rd_s >> lane_shift_s);

    // Load path reads current contents; output is zero unless a read is requested.
    always_comb begin
        mem_rdata_s = 32'd0;
        if (mem_wr_rd == MEM_READ) begin
            mem_rdata_s = word_byte ? sext8(byte_rd_s) : word_rd_s;
        end else begin
            mem_rdata_s = 32'd0;
        end
    end

    assign mem_rdata = mem_rdata_s;

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Directed self-checking bench for alu_dmem_unit.
// Expected ovf values follow the ALU_OVERFLOW_EN macro.
module tb_alu_dmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic [3:0]  alu_ctrl;
    logic        ovf;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_wr_rd;
    logic        word_byte;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    alu_dmem_unit dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .shamt(shamt),
        .op1(op1), .op2(op2), .alu_result(alu_result), .zero_flag(zero_flag),
        .alu_ctrl(alu_ctrl), .ovf(ovf), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wr_rd(mem_wr_rd), .word_byte(word_byte), .mem_rdata(mem_rdata)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b);
        alu_op = op; funct = fn; shamt = sh; op1 = a; op2 = b;
        #1;
    endtask

    // Drive a memory command through one rising edge, then settle.
    task automatic mem_cycle(input logic [1:0] wr, input logic wb,
                             input logic [31:0] addr, input logic [31:0] wdata);
        mem_wr_rd = wr; word_byte = wb; mem_addr = addr; mem_wdata = wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic mem_read(input logic wb, input logic [31:0] addr);
        mem_wr_rd = 2'b01; word_byte = wb; mem_addr = addr; mem_wdata = 32'd0;
        #1;
    endtask

    logic exp_ovf;

    initial begin
`ifdef ALU_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst = 1'b1;
        alu_op = 3'd0; funct = 6'd0; shamt = 5'd0; op1 = 32'd0; op2 = 32'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_wr_rd = 2'b00; word_byte = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state of memory
        mem_read(1'b0, 32'h10);          chk("rst_rd_0x10", mem_rdata, 32'h0);
        mem_read(1'b1, 32'h3FF);         chk("rst_rd_byte", mem_rdata, 32'h0);

        // ALU decode and function
        alu(3'b010, 6'h20, 5'd0, 32'd5, 32'd7);
        chk("add_ctrl", {28'd0, alu_ctrl}, 32'd2);
        chk("add_res", alu_result, 32'd12);
        chk("add_zero", {31'd0, zero_flag}, 32'd0);
        alu(3'b010, 6'h22, 5'd0, 32'd9, 32'd9);
        chk("sub_res", alu_result, 32'd0);
        chk("sub_zero", {31'd0, zero_flag}, 32'd1);
        alu(3'b010, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'd1);
        chk("slt_res", alu_result, 32'd1);
        alu(3'b010, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'd1);
        chk("sltu_ctrl", {28'd0, alu_ctrl}, 32'd9);
        chk("sltu_res", alu_result, 32'd0);
        alu(3'b010, 6'h03, 5'd4, 32'h12345678, 32'h80000000);
        chk("sra_res", alu_result, 32'hF8000000);
        alu(3'b010, 6'h02, 5'd4, 32'h12345678, 32'h80000000);
        chk("srl_res", alu_result, 32'h08000000);
        alu(3'b010, 6'h00, 5'd8, 32'hFFFFFFFF, 32'h000000A5);
        chk("sll_res", alu_result, 32'h0000A500);
        alu(3'b010, 6'h27, 5'd0, 32'hF0F00000, 32'h0000000F);
        chk("nor_ctrl", {28'd0, alu_ctrl}, 32'd12);
        chk("nor_res", alu_result, 32'h0F0FFFF0);
        alu(3'b010, 6'h3F, 5'd0, 32'd5, 32'd7);
        chk("bad_ctrl", {28'd0, alu_ctrl}, 32'd15);
        chk("bad_res", alu_result, 32'd0);
        chk("bad_zero", {31'd0, zero_flag}, 32'd1);
        alu(3'b001, 6'h00, 5'd0, 32'd3, 32'd3);
        chk("beq_ctrl", {28'd0, alu_ctrl}, 32'd6);
        chk("beq_zero", {31'd0, zero_flag}, 32'd1);
        alu(3'b011, 6'h00, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
        chk("and_res", alu_result, 32'h0F000F00);
        alu(3'b100, 6'h00, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
        chk("or_res", alu_result, 32'hFFF0FFF0);
        alu(3'b110, 6'h00, 5'd0, 32'hFF00FF00, 32'h0FF00FF0);
        chk("xor_res", alu_result, 32'hF0F0F0F0);
        alu(3'b101, 6'h00, 5'd0, 32'd1, 32'hFFFFFFFE);
        chk("slti_res", alu_result, 32'd0);
        alu(3'b010, 6'h08, 5'd0, 32'h00400020, 32'd0);
        chk("jr_res", alu_result, 32'h00400020);

        // Overflow
        alu(3'b000, 6'h00, 5'd0, 32'h7FFFFFFF, 32'd1);
        chk("ovf_add_res", alu_result, 32'h80000000);
        chk("ovf_add", {31'd0, ovf}, {31'd0, exp_ovf});
        alu(3'b001, 6'h00, 5'd0, 32'h80000000, 32'd1);
        chk("ovf_sub_res", alu_result, 32'h7FFFFFFF);
        chk("ovf_sub", {31'd0, ovf}, {31'd0, exp_ovf});
        alu(3'b000, 6'h00, 5'd0, 32'h7FFFFFFF, 32'hFFFFFFFF);
        chk("ovf_none", {31'd0, ovf}, 32'd0);

        // Data memory
        mem_read(1'b0, 32'h10);
        mem_wr_rd = 2'b10; mem_wdata = 32'h11223344; #1;
        chk("wr_cycle_rdata", mem_rdata, 32'h0);
        mem_cycle(2'b10, 1'b0, 32'h10, 32'h11223344);
        mem_read(1'b0, 32'h10);          chk("rd_word", mem_rdata, 32'h11223344);
        mem_read(1'b0, 32'h13);          chk("rd_word_unaligned", mem_rdata, 32'h11223344);
        mem_read(1'b1, 32'h13);          chk("rd_byte3", mem_rdata, 32'h00000011);
        mem_read(1'b1, 32'h10);          chk("rd_byte0", mem_rdata, 32'h00000044);
        mem_cycle(2'b10, 1'b1, 32'h11, 32'hABCDEF80);
        mem_read(1'b1, 32'h11);          chk("rd_byte_sext", mem_rdata, 32'hFFFFFF80);
        mem_read(1'b0, 32'h10);          chk("rd_word_merged", mem_rdata, 32'h11228044);
        mem_read(1'b0, 32'h410);         chk("alias", mem_rdata, 32'h11228044);
        mem_cycle(2'b10, 1'b0, 32'h414, 32'hCAFEF00D);
        mem_read(1'b0, 32'h14);          chk("alias_wr", mem_rdata, 32'hCAFEF00D);
        mem_cycle(2'b11, 1'b0, 32'h14, 32'h0);
        mem_read(1'b0, 32'h14);          chk("idle11_nowr", mem_rdata, 32'hCAFEF00D);
        mem_wr_rd = 2'b00; #1;           chk("idle00_rdata", mem_rdata, 32'h0);
        mem_wr_rd = 2'b11; #1;           chk("idle11_rdata", mem_rdata, 32'h0);

        // Reset during a write
        rst = 1'b1;
        mem_cycle(2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
        rst = 1'b0;
        mem_read(1'b0, 32'h20);          chk("rst_wr_discard", mem_rdata, 32'h0);
        mem_read(1'b0, 32'h10);          chk("rst_clear_0x10", mem_rdata, 32'h0);
        mem_read(1'b0, 32'h14);          chk("rst_clear_0x14", mem_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dmem_unit.md
Name: alu_dmem_unit

Overview:
Execute-plus-memory datapath slice of the 5-stage pipelined core: ALU-control decode, 32-bit ALU and byte-addressable data memory in one block.
ALU section is combinational and feeds the EX/MEM register. Memory section consumes the EX/MEM-registered address, write data and controls, and produces read data for the MEM/WB register.

Parameters:
DMEM_WORDS, 256, number of 32-bit data-memory words (power of two).
DMEM_AW, 8, word-index width, equal to log2(DMEM_WORDS).

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
alu_op  input  3  ALU operation class from the control unit
funct  input  6  instruction funct field (R-type)
shamt  input  5  shift amount
op1  input  32  ALU operand A (rs or 0)
op2  input  32  ALU operand B (rt, immediate or PC+8)
alu_result  output  32  combinational ALU result
zero_flag  output  1  1 when alu_result == 0
alu_ctrl  output  4  decoded ALU control (visible for debug)
ovf  output  1  signed overflow (see Optional Feature)
mem_addr  input  32  byte address (EX/MEM ALU result)
mem_wdata  input  32  store data
mem_wr_rd  input  2  00 idle, 01 read, 10 write, 11 idle
word_byte  input  1  0 word access, 1 byte access
mem_rdata  output  32  load data

Behaviour:
- ALU control, combinational:
  - alu_op 000 gives add (2)
  - alu_op 001 gives sub (6)
  - alu_op 011 gives and (0)
  - alu_op 100 gives or (1)
  - alu_op 101 gives slt (7)
  - alu_op 110 gives xor (3)
  - alu_op 111 gives add (2)
  - alu_op 010 decodes funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor (12), 0x2A slt, 0x2B sltu (9), 0x00 sll (4), 0x02 srl (5), 0x03 sra (8), 0x08 jr add (2). Any other funct gives code 15.
- ALU, combinational, 32-bit:
  - add/sub wrap modulo 2^32.
  - slt compares signed; sltu compares unsigned. Result is 1 or 0.
  - nor is ~(op1|op2).
  - Shifts act on op2 by shamt: sll, srl logical; sra arithmetic. op1 is ignored for shifts.
  - Code 15 or any undefined code gives result 0.
  - zero_flag = (alu_result == 0).
  - The ALU holds no state; clk and rst do not affect it.
- Data memory:
  - Little-endian, byte addressed. Word index is mem_addr[DMEM_AW+1:2]; upper address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
  - Word accesses ignore mem_addr[1:0].
  - Write (mem_wr_rd = 10) is synchronous on the rising clk edge:
    - word_byte = 0 stores all 32 bits.
    - word_byte = 1 stores mem_wdata[7:0] into byte lane mem_addr[1:0] only.
  - Read (mem_wr_rd = 01) is combinational from current contents:
    - word_byte = 0 returns the full word.
    - word_byte = 1 returns the addressed byte, sign-extended to 32 bits.
  - mem_rdata = 0 whenever mem_wr_rd is not 01.
  - A read in the same cycle as a write to the same address returns the old contents. The new value is visible after the edge.
- Reset:
  - When rst = 1 at a rising edge, every memory word is cleared to 0 and no write occurs in that cycle; rst has priority over write.
  - After reset, mem_rdata reads 0 for any read.
  - Combinational outputs (alu_result, zero_flag, alu_ctrl, ovf) are independent of rst.
- Reset can be asserted mid-operation: a write pending in the reset cycle is discarded.

Optional Feature:
ALU_OVERFLOW_EN.
- Defined: ovf = 1 when a signed add (code 2) or sub (code 6) overflows, i.e. operand signs produce a result of the wrong sign. ovf = 0 for all other operations. alu_result is still the wrapped value; no trap is raised.
- Not defined: ovf is tied to 0.

Test Plan:
- alu_op=010, funct=0x20, op1=5, op2=7 -> alu_ctrl=2, alu_result=12, zero_flag=0. Repeat with funct=0x22, op1=op2=9 -> alu_result=0, zero_flag=1.
- alu_op=010, funct=0x2A, op1=0xFFFFFFFF, op2=1 -> result 1. Same operands with funct=0x2B -> result 0. funct=0x03, op2=0x80000000, shamt=4 -> 0xF8000000.
- alu_op=010, funct=0x3F -> alu_ctrl=15, alu_result=0, zero_flag=1. alu_op=001, op1=3, op2=3 -> zero_flag=1 (beq taken).
- Write word 0x11223344 to address 0x10, then read word at 0x10 -> 0x11223344. Read byte at 0x13 -> 0x00000011. Store byte 0x80 at 0x11, then read byte at 0x11 -> 0xFFFFFF80, read word at 0x10 -> 0x11228044.
- Write 0xDEADBEEF to 0x20 while rst=1 -> word at 0x20 reads 0 after the edge. With mem_wr_rd=00 -> mem_rdata=0. Address 0x400+0x10 (DMEM_WORDS=256) -> aliases address 0x10.
- With ALU_OVERFLOW_EN defined: add 0x7FFFFFFF+1 -> ovf=1, result 0x80000000. Sub 0x80000000-1 -> ovf=1. Without the macro -> ovf=0 in both cases.
